// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate multiplier and its error-sweep controller:
// operand/product widths, default accumulator widths, sweep FSM states and the
// S1 pipeline payload.
package approx_mult_pkg;

    localparam int unsigned OP_W      = 8;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned SUM_W_DEF = 32;
    localparam int unsigned CNT_W_DEF = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Operands travel with their products so S2 can record the worst-case pair.
    typedef struct packed {
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        logic [PROD_W-1:0] approx;
        logic [PROD_W-1:0] exact;
    } s1_payload_t;

endpackage

// File: rtl/approx_mult_8bit.sv
// 8x8 unsigned truncated approximate multiplier (combinational).
// Partial-product bits whose column weight is below 2^TRUNC_COLS are dropped,
// so the result never exceeds the exact product.
// Ports: a, b (8-bit operands) -> product (16-bit approximate product).
module approx_mult_8bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    localparam int TRUNC_COLS = 6;

    logic [15:0] acc;

    // Sum only the partial-product bits in columns >= TRUNC_COLS.
    always_comb begin
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (i + j >= TRUNC_COLS) begin
                    acc = acc + (16'(a[i] & b[j]) << (i + j));
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/approx_mult_sweep_ctrl.sv
// Error-characterisation engine for approx_mult_8bit. On an accepted start it
// sweeps every (a, b) in [0..a_max] x [0..b_max] (b inner loop), compares the
// approximate product with the exact one and accumulates total/worst-case error.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               sweep request, honoured only in IDLE
//   a_max, b_max        inclusive sweep limits, latched on accepted start
//   busy, done          sweep in flight / one-cycle completion pulse
//   sum_abs_err         total |exact - approx|
//   err_count           pairs with nonzero error
//   pair_count          pairs evaluated
//   max_abs_err         worst |exact - approx|, with operands max_a/max_b
module approx_mult_sweep_ctrl
    import approx_mult_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a_max,
    input  logic [OP_W-1:0]   b_max,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum_abs_err,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  pair_count,
    output logic [PROD_W-1:0] max_abs_err,
    output logic [OP_W-1:0]   max_a,
    output logic [OP_W-1:0]   max_b
);

    state_e            state_q,  state_d;
    logic [OP_W-1:0]   a_lim_q,  a_lim_d;
    logic [OP_W-1:0]   b_lim_q,  b_lim_d;
    logic [OP_W-1:0]   op_a_q,   op_a_d;
    logic [OP_W-1:0]   op_b_q,   op_b_d;
    logic              s0_vld_q, s0_vld_d;
    s1_payload_t       s1_q,     s1_d;
    logic              s1_vld_q, s1_vld_d;
    logic              drain_q,  drain_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [SUM_W-1:0]  sum_q,    sum_d;
    logic [CNT_W-1:0]  errc_q,   errc_d;
    logic [CNT_W-1:0]  pairc_q,  pairc_d;
    logic [PROD_W-1:0] max_q,    max_d;
    logic [OP_W-1:0]   max_a_q,  max_a_d;
    logic [OP_W-1:0]   max_b_q,  max_b_d;

    logic [PROD_W-1:0] approx_c;
    logic [PROD_W-1:0] abs_c;

    // S0: registered operands drive the multiplier.
    approx_mult_8bit u_mult (
        .a       (op_a_q),
        .b       (op_b_q),
        .product (approx_c)
    );

    // S2 absolute difference; compare first so either ordering stays unsigned.
    always_comb begin
        if (s1_q.exact >= s1_q.approx) begin
            abs_c = s1_q.exact - s1_q.approx;
        end else begin
            abs_c = s1_q.approx - s1_q.exact;
        end
    end

    // Next-state: FSM, operand sequencing, pipeline and accumulators.
    always_comb begin
        state_d  = state_q;
        a_lim_d  = a_lim_q;
        b_lim_d  = b_lim_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        s0_vld_d = 1'b0;
        s1_d     = s1_q;
        s1_vld_d = s0_vld_q;
        drain_d  = drain_q;
        sum_d    = sum_q;
        errc_d   = errc_q;
        pairc_d  = pairc_q;
        max_d    = max_q;
        max_a_d  = max_a_q;
        max_b_d  = max_b_q;

        // S1: capture approximate and exact products with their operands.
        if (s0_vld_q) begin
            s1_d.a      = op_a_q;
            s1_d.b      = op_b_q;
            s1_d.approx = approx_c;
            s1_d.exact  = PROD_W'(op_a_q) * PROD_W'(op_b_q);
        end

        // S2: accumulate; strict compare keeps the earliest pair on ties.
        if (s1_vld_q) begin
            sum_d   = sum_q + SUM_W'(abs_c);
            errc_d  = errc_q + CNT_W'(abs_c != '0);
            pairc_d = pairc_q + CNT_W'(1);
            if (abs_c > max_q) begin
                max_d   = abs_c;
                max_a_d = s1_q.a;
                max_b_d = s1_q.b;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_lim_d  = a_max;
                    b_lim_d  = b_max;
                    op_a_d   = '0;
                    op_b_d   = '0;
                    s0_vld_d = 1'b1;
                    sum_d    = '0;
                    errc_d   = '0;
                    pairc_d  = '0;
                    max_d    = '0;
                    max_a_d  = '0;
                    max_b_d  = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // op_a_q/op_b_q hold the pair issued this cycle; advance or stop.
                if (op_b_q != b_lim_q) begin
                    op_b_d   = op_b_q + OP_W'(1);
                    s0_vld_d = 1'b1;
                end else if (op_a_q != a_lim_q) begin
                    op_a_d   = op_a_q + OP_W'(1);
                    op_b_d   = '0;
                    s0_vld_d = 1'b1;
                end else begin
                    drain_d  = 1'b0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Two cycles: last pair moves S1 -> S2 -> accumulators.
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_lim_q  <= '0;
            b_lim_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            s0_vld_q <= 1'b0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            errc_q   <= '0;
            pairc_q  <= '0;
            max_q    <= '0;
            max_a_q  <= '0;
            max_b_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_lim_q  <= a_lim_d;
            b_lim_q  <= b_lim_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            s0_vld_q <= s0_vld_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            errc_q   <= errc_d;
            pairc_q  <= pairc_d;
            max_q    <= max_d;
            max_a_q  <= max_a_d;
            max_b_q  <= max_b_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sum_abs_err = sum_q;
    assign err_count   = errc_q;
    assign pair_count  = pairc_q;
    assign max_abs_err = max_q;
    assign max_a       = max_a_q;
    assign max_b       = max_b_q;

endmodule

// File: tb/tb_approx_mult_sweep_ctrl.sv
// Self-checking bench for approx_mult_sweep_ctrl. A sweep-level model builds
// prefix results for the whole rectangle on each accepted start; every cycle
// the DUT outputs are compared against the prefix matching the number of pairs
// that must have been accumulated by then.
module tb_approx_mult_sweep_ctrl;

    localparam int unsigned SUM_W = 32;
    localparam int unsigned CNT_W = 17;
    localparam int          MAXN  = 65536;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       a_max;
    logic [7:0]       b_max;
    logic             busy;
    logic             done;
    logic [SUM_W-1:0] sum_abs_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] pair_count;
    logic [15:0]      max_abs_err;
    logic [7:0]       max_a;
    logic [7:0]       max_b;

    always #5 clk = ~clk;

    approx_mult_sweep_ctrl #(.SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_max       (a_max),
        .b_max       (b_max),
        .busy        (busy),
        .done        (done),
        .sum_abs_err (sum_abs_err),
        .err_count   (err_count),
        .pair_count  (pair_count),
        .max_abs_err (max_abs_err),
        .max_a       (max_a),
        .max_b       (max_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Approximate product = exact product minus the dropped low-column terms,
    // summed row by row: row i keeps b bits j with i + j < 6.
    function automatic int model_approx(input int a, input int b);
        int low = 0;
        for (int i = 0; i < 6; i++)
            if (((a >> i) & 1) == 1)
                low += (b & ((1 << (6 - i)) - 1)) << i;
        return a * b - low;
    endfunction

    // Prefix results after m pairs of the current sweep.
    int unsigned m_sum [0:MAXN];
    int          m_err [0:MAXN];
    int          m_max [0:MAXN];
    int          m_ma  [0:MAXN];
    int          m_mb  [0:MAXN];
    bit          started = 1'b0;
    int          p_acc   = 0;
    int          n_pairs = 0;

    task automatic build(input int am, input int bm);
        int idx = 0;
        int e;
        n_pairs  = (am + 1) * (bm + 1);
        m_sum[0] = 0; m_err[0] = 0; m_max[0] = 0; m_ma[0] = 0; m_mb[0] = 0;
        for (int a = 0; a <= am; a++) begin
            for (int b = 0; b <= bm; b++) begin
                e = a * b - model_approx(a, b);
                if (e < 0) e = -e;
                idx++;
                m_sum[idx] = m_sum[idx-1] + e;
                m_err[idx] = m_err[idx-1] + ((e != 0) ? 1 : 0);
                if (e > m_max[idx-1]) begin
                    m_max[idx] = e; m_ma[idx] = a; m_mb[idx] = b;
                end else begin
                    m_max[idx] = m_max[idx-1]; m_ma[idx] = m_ma[idx-1]; m_mb[idx] = m_mb[idx-1];
                end
            end
        end
    endtask

    // Model update: a start is taken only if the engine was idle in the cycle
    // that just ended (never started, or past its done cycle).
    always @(posedge clk) begin
        if (rst) begin
            started = 1'b0;
        end else if (start && (!started || cyc >= p_acc + n_pairs + 3)) begin
            started = 1'b1;
            p_acc   = cyc + 1;
            build(int'(a_max), int'(b_max));
        end
        cyc++;
    end

    // Per-cycle compare against the model.
    int done_cnt = 0;
    always @(negedge clk) begin
        int m;
        if (done === 1'b1) done_cnt++;
        if (cyc > 0) begin
            if (!started) begin
                check("busy_idle", busy, 0);
                check("done_idle", done, 0);
                check("sum_idle", sum_abs_err, 0);
                check("errcnt_idle", err_count, 0);
                check("paircnt_idle", pair_count, 0);
                check("max_idle", max_abs_err, 0);
                check("maxa_idle", max_a, 0);
                check("maxb_idle", max_b, 0);
            end else begin
                m = cyc - p_acc - 1;
                if (m < 0) m = 0;
                if (m > n_pairs) m = n_pairs;
                check("busy", busy, (cyc >= p_acc && cyc <= p_acc + n_pairs + 1) ? 1 : 0);
                check("done", done, (cyc == p_acc + n_pairs + 2) ? 1 : 0);
                check("sum_abs_err", sum_abs_err, m_sum[m]);
                check("err_count", err_count, m_err[m]);
                check("pair_count", pair_count, m);
                check("max_abs_err", max_abs_err, m_max[m]);
                check("max_a", max_a, m_ma[m]);
                check("max_b", max_b, m_mb[m]);
            end
        end
    end

    task automatic do_start(input int am, input int bm, output int k);
        @(negedge clk);
        a_max = 8'(am);
        b_max = 8'(bm);
        start = 1'b1;
        k     = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int w = 0;
        dcyc = -1;
        while (done !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        if (done === 1'b1) dcyc = cyc;
        else check("done_timeout", 0, 1);
    endtask

    initial begin
        int k, dcyc, d0, am, bm;
        int mae_x1e4;

        rst = 1'b1; start = 1'b0; a_max = '0; b_max = '0;

        // Model pins: hand-computed truncated products.
        check("model_255x255", model_approx(255, 255), 64704);
        check("model_63x63", model_approx(63, 63), 3648);
        check("model_3x5", model_approx(3, 5), 0);
        check("model_64x64", model_approx(64, 64), 4096);

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_paircnt", pair_count, 0);
        rst = 1'b0;

        // Single pair.
        do_start(0, 0, k);
        wait_done(20, dcyc);
        check("lat_1x1", dcyc - k, 4);
        check("pc_1x1", pair_count, 1);
        check("sum_1x1", sum_abs_err, 0);
        check("max_1x1", max_abs_err, 0);
        check("maxab_1x1", {max_a, max_b}, 0);
        repeat (2) @(negedge clk);

        // 4x6: every product truncates to zero, so error = a*b.
        do_start(3, 5, k);
        wait_done(60, dcyc);
        check("lat_4x6", dcyc - k, 27);
        check("pc_4x6", pair_count, 24);
        check("sum_4x6", sum_abs_err, 90);
        check("err_4x6", err_count, 15);
        check("max_4x6", max_abs_err, 15);
        check("maxa_4x6", max_a, 3);
        check("maxb_4x6", max_b, 5);
        repeat (3) @(negedge clk);

        // 16x16 with stray starts mid-sweep and on the done cycle.
        d0 = done_cnt;
        do_start(15, 15, k);
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400, dcyc);
        check("lat_16x16", dcyc - k, 259);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("done_once_16x16", done_cnt - d0, 1);
        check("pc_16x16", pair_count, 256);
        check("busy_after_16x16", busy, 0);

        // Random rectangles.
        for (int r = 0; r < 5; r++) begin
            am = int'($urandom_range(0, 40));
            bm = int'($urandom_range(0, 40));
            do_start(am, bm, k);
            wait_done(2000, dcyc);
            check("lat_rand", dcyc - k, (am + 1) * (bm + 1) + 3);
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        // Full sweep interrupted by reset: nothing partial survives.
        do_start(255, 255, k);
        repeat (98) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_sum", sum_abs_err, 0);
        check("abort_paircnt", pair_count, 0);
        check("abort_max", max_abs_err, 0);
        rst = 1'b0;

        // Full sweep. Error depends only on the low 6 bits of each operand, so
        // the worst case (321 at 63,63) repeats; the first occurrence must win.
        do_start(255, 255, k);
        wait_done(70000, dcyc);
        check("lat_full", dcyc - k, 65539);
        check("pc_full", pair_count, 65536);
        check("sum_full", sum_abs_err, 5259264);
        check("max_full", max_abs_err, 321);
        check("maxa_full_tie", max_a, 63);
        check("maxb_full_tie", max_b, 63);
        mae_x1e4 = $rtoi(real'(sum_abs_err) / 65536.0 * 10000.0 + 0.5);
        check("mae_full", mae_x1e4, $rtoi(real'(m_sum[65536]) / 65536.0 * 10000.0 + 0.5));
        check("mae_full_lit", mae_x1e4, 802500);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_mult_sweep_ctrl.md
# approx_mult_sweep_ctrl

Hardware error-characterisation engine for the 8x8 approximate multiplier. On a start pulse it sweeps operand pairs (a, b) over a programmed rectangle through an internal `approx_mult_8bit` instance and compares each result against the exact product. It accumulates total absolute error, error count and worst-case error with its operands, then pulses `done`. It sits beside the multiplier as an on-chip replacement for the software error sweep, and its results feed the MAE/MRED reporting path.

## Interface
Parameters:
- SUM_W, 32, width of absolute-error accumulator (≥32 for full 65536-pair sweep)
- CNT_W, 17, width of pair/error counters (must hold 65536)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- a_max  in  8  last value of a in sweep; sampled on accepted start
- b_max  in  8  last value of b in sweep; sampled on accepted start
- busy  out  1  high from cycle after accepted start until done cycle (exclusive)
- done  out  1  one-cycle pulse when results final
- sum_abs_err  out  SUM_W  Σ|exact − approx|
- err_count  out  CNT_W  number of pairs with nonzero error
- pair_count  out  CNT_W  pairs evaluated
- max_abs_err  out  16  largest |exact − approx|
- max_a, max_b  out  8 each  operands of first pair reaching max_abs_err

## Operation
- FSM: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: start=1 latches a_max/b_max, clears all result registers, zeroes operand counters, goes to RUN.
- RUN: issues one pair per cycle, b inner loop 0..b_max, a outer loop 0..a_max, i.e. order (0,0),(0,1)…(0,b_max),(1,0)…(a_max,b_max). After issuing (a_max,b_max) goes to DRAIN.
- DRAIN: 2 cycles flushing the pipeline; then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Pipeline per pair:
  - S0: registered operands drive multiplier.
  - S1: register approx product (16b) and exact a*b (16b, unsigned) plus operands.
  - S2: abs = |exact − approx| (16b, unsigned compare then subtract). Update sum_abs_err += abs, pair_count += 1, err_count += (abs≠0). Update max only if abs > max_abs_err (strict); ties keep earlier pair.
- Results hold after done until the next accepted start.
- start while busy or in DONE: ignored, no effect on sweep.
- sum_abs_err does not wrap for SUM_W≥32 (bound 65536·65535 < 2^32); behaviour for narrower SUM_W is modulo 2^SUM_W.

## Timing
- Reset (any state, mid-sweep included): next edge FSM=IDLE; busy=0, done=0, all result outputs 0, counters 0, pipeline valid bits 0. No partial results survive.
- Start accepted at edge k → busy=1 from k+1; pair n issued at k+1+n; accumulated at k+3+n.
- N=(a_max+1)(b_max+1). Last accumulation at k+N+2; done=1 and busy=0 at k+N+3.
- Full sweep (255,255): done at k+65539.
- start coincident with done cycle: ignored (FSM not IDLE).
- Outputs are registers; no combinational input→output paths.

## Structure
- Shared package `approx_mult_pkg`: state enum (IDLE/RUN/DRAIN/DONE), operand width 8, product width 16, default SUM_W/CNT_W.
- One sub-module: existing `approx_mult_8bit` (a, b, product), instantiated unmodified.
- Pipeline valid bit per stage; no separate abs-diff module.

## Test plan
- a_max=0, b_max=0, start at k → done at k+4; pair_count=1; sum/err/max equal bench model of approx(0,0) vs 0; max_a=max_b=0.
- a_max=3, b_max=5 → pair_count=24, done at k+27; all results match bench golden loop over same order, using the reference multiplier instance.
- Full sweep (255,255) → pair_count=65536, done at k+65539; sum_abs_err matches bench total absolute error; MAE = sum/65536 matches golden to 4 decimals.
- Reset asserted at k+100 of full sweep → next cycle busy=0, all outputs 0; new start then completes normally with full-sweep values.
- start pulsed at k+10 and on the done cycle of a (15,15) sweep → ignored; exactly one done; results unchanged.
- Tie check: bench forces golden max at two pairs → max_a/max_b report the earlier pair in sweep order.
